lw_data_mem: RTL and testbench

Word-addressed data memory stage that sits directly downstream of the ALU in the load-word datapath. It consumes the ALU result as a byte address and performs one load or store per request through a valid/ready handshake. Access latency is a configurable number of wait states, and every request returns exactly one response pulse with an error flag. Misaligned and out-of-range addresses are flagged and never touch the array.

---
 rtl/lw_data_mem_if.sv | 27 ++
 rtl/lw_data_mem.sv | 117 +++++++++++
 tb/tb_lw_data_mem.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/lw_data_mem_if.sv
// Request/response bus of the load-word data memory stage.
// Ports (via modports):
//   master: drives req_valid, we, addr, wdata; observes req_ready, rsp_valid, rdata, err, busy
//   slave : the memory side, the mirror image of master
interface lw_data_mem_if #(
  parameter int unsigned M = 32
);
  logic         req_valid;
  logic         req_ready;
  logic         we;
  logic [M-1:0] addr;
  logic [M-1:0] wdata;
  logic         rsp_valid;
  logic [M-1:0] rdata;
  logic         err;
  logic         busy;

  modport master (
    output req_valid, we, addr, wdata,
    input  req_ready, rsp_valid, rdata, err, busy
  );

  modport slave (
    input  req_valid, we, addr, wdata,
    output req_ready, rsp_valid, rdata, err, busy
  );
endinterface

// File: rtl/lw_data_mem.sv
// Word-addressed data memory stage fed by the ALU result (byte address).
// One load or store per valid/ready request, WAIT wait states, then a single
// one-cycle response pulse with an error flag. Misaligned or out-of-range
// addresses are flagged and never touch the array.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset (the array itself is not reset)
//   bus   - lw_data_mem_if.slave: request (req_valid/we/addr/wdata/req_ready),
//           response (rsp_valid/rdata/err) and busy status
module lw_data_mem #(
  parameter int unsigned M     = 32,
  parameter int unsigned DEPTH = 64,
  parameter int unsigned WAIT  = 2
) (
  input logic          clk,
  input logic          rst_n,
  lw_data_mem_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e       state_q;
  logic [2:0]   cnt_q;
  logic         ready_q;
  logic         we_q;
  logic [M-1:0] addr_q;
  logic [M-1:0] wdata_q;
  logic         rsp_valid_q;
  logic [M-1:0] rdata_q;
  logic         err_q;

  logic [M-1:0] mem [DEPTH];

  logic         accept;
  logic         access;
  logic         acc_we;
  logic [M-1:0] acc_addr;
  logic [M-1:0] acc_wdata;
  logic [M-3:0] acc_idx;
  logic         acc_err;

  // With WAIT=0 the access edge is the acceptance edge itself, so the access
  // must use the live request; otherwise it uses the latched copy.
  always_comb begin
    accept    = bus.req_valid && ready_q;
    acc_we    = (state_q == StIdle) ? bus.we    : we_q;
    acc_addr  = (state_q == StIdle) ? bus.addr  : addr_q;
    acc_wdata = (state_q == StIdle) ? bus.wdata : wdata_q;
    acc_idx   = acc_addr[M-1:2];
    acc_err   = (acc_addr[1:0] != 2'b00) || ((acc_idx >> AW) != '0);
    // rst_n gating keeps a clock edge during reset from committing a store.
    access    = rst_n &&
                (((state_q == StIdle) && accept && (WAIT == 0)) ||
                 ((state_q == StWait) && (cnt_q == 3'd0)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= 3'd0;
      ready_q     <= 1'b1;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      if (access) begin
        state_q     <= StResp;
        ready_q     <= 1'b0;
        rsp_valid_q <= 1'b1;
        err_q       <= acc_err;
        rdata_q     <= (!acc_err && !acc_we) ? mem[acc_idx[AW-1:0]] : '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (accept) begin
              we_q    <= bus.we;
              addr_q  <= bus.addr;
              wdata_q <= bus.wdata;
              cnt_q   <= 3'(WAIT - 1);
              state_q <= StWait;
              ready_q <= 1'b0;
            end
          end
          StWait: cnt_q <= cnt_q - 3'd1;
          StResp: begin
            state_q <= StIdle;
            ready_q <= 1'b1;
          end
          default: begin
            state_q <= StIdle;
            ready_q <= 1'b1;
          end
        endcase
      end
    end
  end

  // Array has no reset; only error-free stores on the access edge write it.
  always_ff @(posedge clk) begin
    if (access && !acc_err && acc_we) begin
      mem[acc_idx[AW-1:0]] <= acc_wdata;
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.busy      = !ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rdata     = rdata_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_lw_data_mem.sv
// Self-checking bench for lw_data_mem: one instance with WAIT=2, one with WAIT=0.
module tb_lw_data_mem;

  localparam int unsigned W0 = 2;
  localparam int unsigned W1 = 0;

  logic        clk;
  logic        rst_n;
  bit          sel;
  logic        req_valid;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;

  int n_chk  = 0;
  int n_pass = 0;

  lw_data_mem_if #(.M(32)) b0 ();
  lw_data_mem_if #(.M(32)) b1 ();

  assign b0.req_valid = req_valid && !sel;
  assign b1.req_valid = req_valid && sel;
  assign b0.we    = we;
  assign b1.we    = we;
  assign b0.addr  = addr;
  assign b1.addr  = addr;
  assign b0.wdata = wdata;
  assign b1.wdata = wdata;

  lw_data_mem #(.M(32), .DEPTH(64), .WAIT(W0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  lw_data_mem #(.M(32), .DEPTH(64), .WAIT(W1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

  logic        rdy_s, rsp_s, err_s, busy_s;
  logic [31:0] rdata_s;
  assign rdy_s   = sel ? b1.req_ready : b0.req_ready;
  assign rsp_s   = sel ? b1.rsp_valid : b0.rsp_valid;
  assign err_s   = sel ? b1.err       : b0.err;
  assign busy_s  = sel ? b1.busy      : b0.busy;
  assign rdata_s = sel ? b1.rdata     : b0.rdata;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  // Full transaction: accept, scramble inputs, wait for the response, check it.
  task automatic do_req(input bit s, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rd, input logic exp_e, input string nm);
    int lat;
    int exp_lat;
    exp_lat = s ? int'(W1) + 1 : int'(W0) + 1;
    @(negedge clk);
    sel = s; we = w; addr = a; wdata = d; req_valid = 1'b1;
    chk({nm, "_ready"}, {31'd0, rdy_s}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0; we = ~w; addr = 32'hFFFF_FFFF; wdata = 32'hCAFE_F00D;
    lat = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(negedge clk);
      if (rsp_s) lat = k;
    end
    chk({nm, "_latency"}, lat, exp_lat);
    chk({nm, "_rdata"}, rdata_s, exp_rd);
    chk({nm, "_err"}, {31'd0, err_s}, {31'd0, exp_e});
    @(negedge clk);
    chk({nm, "_pulse_end"}, {31'd0, rsp_s}, 32'd0);
    chk({nm, "_rdata_hold"}, rdata_s, exp_rd);
  endtask

  // Accept a request, then pulse reset one time unit after the acceptance edge.
  task automatic reset_abort(input bit s, input logic w, input logic [31:0] a,
                             input logic [31:0] d, input string nm);
    int nrsp;
    @(negedge clk);
    sel = s; we = w; addr = a; wdata = d; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk({nm, "_busy_pre"}, {31'd0, busy_s}, 32'd1);
    chk({nm, "_rsp_pre"}, {31'd0, rsp_s}, s ? 32'd1 : 32'd0);
    rst_n = 1'b0;
    #1;
    chk({nm, "_rst_ready"}, {31'd0, rdy_s}, 32'd1);
    chk({nm, "_rst_busy"}, {31'd0, busy_s}, 32'd0);
    chk({nm, "_rst_rsp"}, {31'd0, rsp_s}, 32'd0);
    chk({nm, "_rst_rdata"}, rdata_s, 32'd0);
    chk({nm, "_rst_err"}, {31'd0, err_s}, 32'd0);
    #1;
    rst_n = 1'b1;
    nrsp = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (rsp_s) nrsp++;
    end
    chk({nm, "_no_rsp"}, nrsp, 0);
  endtask

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] rd;
    logic        e;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [11:0] acc_mask;
    logic [11:0] rsp_mask;

    vecs[0] = '{1'b1, 32'h10,  32'hDEAD_BEEF, 32'h0,         1'b0};
    vecs[1] = '{1'b0, 32'h10,  32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[2] = '{1'b1, 32'h12,  32'h1234_5678, 32'h0,         1'b1};
    vecs[3] = '{1'b0, 32'h10,  32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[4] = '{1'b0, 32'h13,  32'h0,         32'h0,         1'b1};
    vecs[5] = '{1'b0, 32'h100, 32'h0,         32'h0,         1'b1};
    vecs[6] = '{1'b1, 32'hFC,  32'hA5A5_A5A5, 32'h0,         1'b0};
    vecs[7] = '{1'b0, 32'hFC,  32'h0,         32'hA5A5_A5A5, 1'b0};
    vecs[8] = '{1'b1, 32'h100, 32'h5555_5555, 32'h0,         1'b1};
    vecs[9] = '{1'b0, 32'hFC,  32'h0,         32'hA5A5_A5A5, 1'b0};

    sel = 1'b0; req_valid = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_ready", {31'd0, rdy_s}, 32'd1);
    chk("reset_busy", {31'd0, busy_s}, 32'd0);
    chk("reset_rsp", {31'd0, rsp_s}, 32'd0);
    chk("reset_rdata", rdata_s, 32'd0);
    chk("reset_err", {31'd0, err_s}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      do_req(1'b0, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].rd, vecs[i].e,
             $sformatf("v%0d", i));
    end

    // Held request: accepts at cycles 0,4,8; responses at 3,7,11.
    acc_mask = '0;
    rsp_mask = '0;
    @(negedge clk);
    sel = 1'b0; we = 1'b0; addr = 32'h10; wdata = '0; req_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      if (rdy_s) acc_mask[i] = 1'b1;
      if (rsp_s) begin
        rsp_mask[i] = 1'b1;
        chk($sformatf("held_rdata_%0d", i), rdata_s, 32'hDEAD_BEEF);
      end
    end
    req_valid = 1'b0;
    chk("held_accepts", {20'd0, acc_mask}, 32'h111);
    chk("held_rsps", {20'd0, rsp_mask}, 32'h888);

    // Reset during the wait states of a load with non-zero rdata held.
    reset_abort(1'b0, 1'b0, 32'h10, 32'h0, "abort_load");

    // Reset mid-store, WAIT=2: the second store is discarded.
    do_req(1'b0, 1'b1, 32'h20, 32'h1111_1111, 32'h0, 1'b0, "w2_st1");
    reset_abort(1'b0, 1'b1, 32'h20, 32'h2222_2222, "w2_abort");
    do_req(1'b0, 1'b0, 32'h20, 32'h0, 32'h1111_1111, 1'b0, "w2_ld");

    // WAIT=0: acceptance edge is the access edge, so a reset in RESP comes
    // after the store has committed.
    do_req(1'b1, 1'b1, 32'h20, 32'h1111_1111, 32'h0, 1'b0, "w0_st1");
    do_req(1'b1, 1'b0, 32'h20, 32'h0, 32'h1111_1111, 1'b0, "w0_ld1");
    reset_abort(1'b1, 1'b1, 32'h20, 32'h2222_2222, "w0_abort");
    do_req(1'b1, 1'b0, 32'h20, 32'h0, 32'h2222_2222, 1'b0, "w0_ld2");
    do_req(1'b1, 1'b0, 32'h11, 32'h0, 32'h0, 1'b1, "w0_misalign");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
